ysyx_22040632_ifu: RTL and testbench

Instruction fetch unit directly upstream of the decode stage. It holds the architectural fetch PC, issues 32-bit fetch requests to instruction memory over a valid/ready request plus valid response interface, and buffers each returned word. It presents the word and its PC to decode with a valid/ready handshake and accepts control-flow redirects (jal/jalr/branch targets) from the execute side, discarding any in-flight stale fetch.

---
 rtl/ysyx_22040632_ifu.sv | 133 +++++++++++++
 tb/tb_ysyx_22040632_ifu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch unit: holds the fetch PC, requests words from instruction memory,
// buffers each word for decode, and applies redirects from execute (stale words are killed).
module ysyx_22040632_ifu #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_err,
    output logic [63:0]       fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic              kill, kill_n;
    logic [31:0]       inst_n;
    logic [ADDR_W-1:0] pc_n;
    logic              fetch_err_n;
    logic [63:0]       fetch_cnt_n;
    logic              redir_ok, redir_bad;

    assign redir_ok       = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == S_HOLD);

    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        kill_n      = kill;
        inst_n      = inst;
        pc_n        = pc;
        fetch_err_n = fetch_err;
        fetch_cnt_n = fetch_cnt;

        if (state == S_HALT) begin
            state_n = S_HALT;
        end else if (redir_bad) begin
            fetch_err_n = 1'b1;
            state_n     = S_HALT;
        end else if (redir_ok) begin
            // A redirect overrides every other event; an accepted request becomes stale.
            fetch_pc_n = redirect_pc;
            case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        kill_n  = 1'b1;
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        kill_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        kill_n  = 1'b1;
                    end
                end
                S_HOLD:  state_n = S_REQ;
                default: state_n = state;
            endcase
        end else begin
            case (state)
                S_IDLE: state_n = S_REQ;
                S_REQ:  if (imem_req_ready) state_n = S_WAIT;
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill) begin
                            kill_n  = 1'b0;
                            state_n = S_REQ;
                        end else begin
                            inst_n  = imem_resp_data;
                            pc_n    = fetch_pc;
                            state_n = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_pc_n  = fetch_pc + ADDR_W'(4);
                        fetch_cnt_n = fetch_cnt + 64'd1;
                        state_n     = S_REQ;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            kill      <= 1'b0;
            inst      <= '0;
            pc        <= '0;
            fetch_err <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            kill      <= kill_n;
            inst      <= inst_n;
            pc        <= pc_n;
            fetch_err <= fetch_err_n;
            fetch_cnt <= fetch_cnt_n;
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
// Randomized bench for ysyx_22040632_ifu: a random-latency memory and a stream-level model
// that predicts the next delivered PC, its word, and the delivered-instruction count.
module tb_ysyx_22040632_ifu;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_err;
    logic [63:0] fetch_cnt;

    ysyx_22040632_ifu #(.ADDR_W(64), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_err       (fetch_err),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: PC of the next instruction decode should see, and its count.
    logic [63:0] exp_pc;
    logic [63:0] exp_cnt;
    int          n_deliv;

    // Memory model: at most one outstanding request.
    bit          mem_pending;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic [63:0] accepted_q[$];

    // Stimulus knobs (percentages and max latency).
    int p_req_ready, p_inst_ready, p_redirect, max_lat;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        exp_pc      = RESET_PC;
        exp_cnt     = 64'd0;
        mem_pending = 1'b0;
        mem_cnt     = 0;
        accepted_q.delete();
    endtask

    task automatic step();
        int r;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_addr);
                mem_pending     = 1'b0;
            end
        end
        imem_req_ready = ($urandom_range(99) < p_req_ready);
        inst_ready     = ($urandom_range(99) < p_inst_ready);
        redirect_valid = ($urandom_range(99) < p_redirect);
        r = int'($urandom_range(15));
        if (r == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        else        redirect_pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};

        check("fetch_cnt", fetch_cnt, exp_cnt);
        check("fetch_err", {63'd0, fetch_err}, 64'd0);
        check("req_and_inst_exclusive", {63'd0, imem_req_valid & inst_valid}, 64'd0);
        if (inst_valid) begin
            check("inst_pc", pc, exp_pc);
            check("inst_word", {32'd0, inst}, {32'd0, mem_word(exp_pc)});
        end
        if (imem_req_valid) begin
            check("req_addr", imem_req_addr, exp_pc);
            if (imem_req_ready) begin
                mem_pending = 1'b1;
                mem_cnt     = 1 + int'($urandom_range(max_lat - 1));
                mem_addr    = imem_req_addr;
                accepted_q.push_back(imem_req_addr);
            end
        end

        if (redirect_valid) begin
            exp_pc = redirect_pc;
        end else if (inst_valid && inst_ready) begin
            exp_pc  = exp_pc + 64'd4;
            exp_cnt = exp_cnt + 64'd1;
            n_deliv++;
        end
    endtask

    task automatic set_knobs(input int rr, input int ir, input int rd, input int lat);
        p_req_ready  = rr;
        p_inst_ready = ir;
        p_redirect   = rd;
        max_lat      = lat;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
        check({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
        check({tag, "_fetch_err"}, {63'd0, fetch_err}, 64'd0);
        check({tag, "_fetch_cnt"}, fetch_cnt, 64'd0);
        check({tag, "_pc"}, pc, 64'd0);
        check({tag, "_inst"}, {32'd0, inst}, 64'd0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        n_deliv         = 0;
        model_reset();
        set_knobs(100, 100, 0, 1);
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Ideal memory and decode: three sequential fetches in ten cycles.
        repeat (10) step();
        check("ideal_cnt", fetch_cnt, 64'd3);
        check("ideal_addr0", accepted_q[0], 64'h8000_0000);
        check("ideal_addr1", accepted_q[1], 64'h8000_0004);
        check("ideal_addr2", accepted_q[2], 64'h8000_0008);

        // Decode stalls, slow memory, then mixed traffic with redirects.
        set_knobs(80, 10, 0, 4);
        repeat (300) step();
        set_knobs(60, 60, 12, 5);
        repeat (2000) step();
        set_knobs(100, 100, 30, 1);
        repeat (500) step();
        check("progress", {63'd0, n_deliv > 200}, 64'd1);

        // Misaligned redirect halts fetch permanently.
        @(negedge clk);
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h8000_0102;
        @(negedge clk);
        redirect_valid  = 1'b0;
        check("halt_err", {63'd0, fetch_err}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            imem_req_ready  = 1'b1;
            inst_ready      = 1'b1;
            imem_resp_valid = $urandom_range(1) == 1;
            redirect_valid  = $urandom_range(1) == 1;
            redirect_pc     = 64'h8000_0200;
            @(negedge clk);
            check("halt_req_valid", {63'd0, imem_req_valid}, 64'd0);
            check("halt_inst_valid", {63'd0, inst_valid}, 64'd0);
            check("halt_err_sticky", {63'd0, fetch_err}, 64'd1);
        end

        // Asynchronous reset pulse mid-cycle restarts from RESET_PC.
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("rereset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_deliv = 0;
        set_knobs(100, 100, 0, 1);
        repeat (8) step();
        check("restart_addr", accepted_q[0], RESET_PC);
        check("restart_cnt", fetch_cnt, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
